// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler: paces FIFO-buffered samples into dac_spi on a fixed tick,
// repeating the last sample on underrun and counting late ticks.
module dac_sample_scheduler #(
   parameter int CLKS_PER_SAMPLE = 1000,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic                              clock_in,
   input  logic                              reset,
   input  logic                              enable,
   input  logic [15:0]                       in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [15:0]                       dac_data,
   output logic                              dac_rq,
   input  logic                              dac_st,
   output logic                              busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic [15:0]                       underrun_count,
   output logic [7:0]                        late_count,
   input  logic                              clear_counts
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH+1);
   localparam int TW = $clog2(CLKS_PER_SAMPLE);
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
   state_t state, state_nx;
   logic [TW-1:0] tcnt;
   logic [15:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic dac_st_q, tick, idle, empty, full, push, pop, st_fall;
   assign tick     = enable && tcnt == TW'(CLKS_PER_SAMPLE-1);
   assign idle     = state == ST_IDLE;
   assign busy     = !idle;
   assign empty    = fifo_level == '0;
   assign full     = fifo_level == LW'(FIFO_DEPTH);
   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign pop      = tick && idle && !empty;
   assign st_fall  = dac_st_q && !dac_st;
   always_comb begin
      state_nx = ST_IDLE;
      case (state)
         ST_IDLE: state_nx = tick ? ST_REQ : ST_IDLE;
         ST_REQ:  state_nx = dac_st ? ST_WAIT : ST_REQ;
         ST_WAIT: state_nx = st_fall ? ST_IDLE : ST_WAIT;
         default: state_nx = ST_IDLE;
      endcase
   end
   always_ff @(posedge clock_in or negedge reset)
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   // Storage needs no reset; occupancy is tracked by the reset pointers/level.
   always_ff @(posedge clock_in)
      if (push) mem[wptr] <= in_data;
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         tcnt           <= '0;
         wptr           <= '0;
         rptr           <= '0;
         fifo_level     <= '0;
         dac_data       <= 16'h8000;
         dac_rq         <= 1'b0;
         dac_st_q       <= 1'b0;
         underrun_count <= '0;
         late_count     <= '0;
      end else begin
         tcnt       <= (!enable || tick) ? '0 : tcnt + 1'b1;
         wptr       <= push ? wptr + 1'b1 : wptr;
         rptr       <= pop ? rptr + 1'b1 : rptr;
         fifo_level <= fifo_level + LW'(push) - LW'(pop);
         dac_data   <= pop ? mem[rptr] : dac_data;
         dac_rq     <= state_nx == ST_REQ;
         dac_st_q   <= dac_st;
         underrun_count <= clear_counts ? '0
                         : (tick && idle && empty && underrun_count != 16'hFFFF) ? underrun_count + 1'b1
                         : underrun_count;
         late_count <= clear_counts ? '0
                     : (tick && !idle && late_count != 8'hFF) ? late_count + 1'b1
                     : late_count;
      end
   end
endmodule

// File: tb/tb_dac_sample_scheduler.sv
// tb_dac_sample_scheduler: directed test of dac_sample_scheduler with a hand-driven dac_spi.
module tb_dac_sample_scheduler;
   logic clk = 0, rst_n, enable, in_valid, in_ready, dac_rq, dac_st, busy, clear_counts;
   logic [15:0] in_data, dac_data, underrun_count;
   logic [7:0] late_count;
   logic [4:0] fifo_level;
   int cyc = 0, n_cmp = 0, n_bad = 0;
   int t, t2, c, cnt;
   logic [15:0] words [3] = '{16'h1234, 16'h5678, 16'h9ABC};

   dac_sample_scheduler #(.CLKS_PER_SAMPLE(200), .FIFO_DEPTH(16)) dut (
      .clock_in(clk), .reset(rst_n), .enable(enable), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .dac_data(dac_data), .dac_rq(dac_rq),
      .dac_st(dac_st), .busy(busy), .fifo_level(fifo_level),
      .underrun_count(underrun_count), .late_count(late_count), .clear_counts(clear_counts)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input logic [15:0] w);
      in_data = w;
      in_valid = 1;
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic wait_rq(output int tr);
      int n = 0;
      while (!dac_rq && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      tr = cyc;
      if (!dac_rq) chk("rq_timeout", 0, 1);
   endtask

   task automatic serve();
      int n = 0;
      repeat (2) @(negedge clk);
      dac_st = 1;
      while (dac_rq && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("serve_rq_low", dac_rq, 0);
      repeat (3) @(negedge clk);
      dac_st = 0;
      @(posedge clk); #1;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   initial begin
      rst_n = 0; enable = 0; in_valid = 0; in_data = 0; dac_st = 0; clear_counts = 0;
      repeat (3) @(negedge clk);
      chk("rst_rq", dac_rq, 0);
      chk("rst_data", dac_data, 16'h8000);
      chk("rst_level", fifo_level, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_under", underrun_count, 0);
      chk("rst_late", late_count, 0);
      rst_n = 1;
      @(negedge clk);
      // normal playout
      for (int i = 0; i < 3; i++) push(words[i]);
      chk("lvl_3", fifo_level, 3);
      c = cyc;
      enable = 1;
      for (int i = 0; i < 3; i++) begin
         wait_rq(t);
         chk("rq_lat", t, c + 200*(i+1));
         chk("play_data", dac_data, words[i]);
         chk("play_lvl", fifo_level, 2 - i);
         serve();
      end
      // underrun repeats last sample
      for (int i = 0; i < 2; i++) begin
         wait_rq(t);
         chk("ur_lat", t, c + 200*(i+4));
         chk("ur_data", dac_data, 16'h9ABC);
         chk("ur_count", underrun_count, i + 1);
         serve();
      end
      @(negedge clk); clear_counts = 1;
      @(negedge clk); clear_counts = 0;
      chk("ur_clear", underrun_count, 0);
      // stuck DAC drops ticks without popping
      push(16'hAAAA);
      push(16'hBBBB);
      wait_rq(t);
      chk("stk_lat", t, c + 1200);
      chk("stk_data", dac_data, 16'hAAAA);
      chk("stk_lvl0", fifo_level, 1);
      repeat (2) @(negedge clk);
      dac_st = 1;
      repeat (450) @(negedge clk);
      chk("stk_rq", dac_rq, 0);
      chk("stk_late", late_count, 2);
      chk("stk_lvl", fifo_level, 1);
      chk("stk_hold", dac_data, 16'hAAAA);
      dac_st = 0;
      @(posedge clk); #1;
      chk("stk_busy", busy, 0);
      wait_rq(t2);
      chk("stk_next_lat", t2, t + 600);
      chk("stk_next_data", dac_data, 16'hBBBB);
      chk("stk_next_lvl", fifo_level, 0);
      chk("stk_under", underrun_count, 0);
      serve();
      // fill to full, overflow attempt, push+pop at 15
      @(negedge clk);
      enable = 0;
      for (int i = 0; i < 16; i++) begin
         in_data = 16'h1000 + 16'(i);
         in_valid = 1;
         @(negedge clk);
      end
      chk("full_ready", in_ready, 0);
      chk("full_lvl", fifo_level, 16);
      in_data = 16'hDEAD;
      @(negedge clk);
      in_valid = 0;
      chk("ovf_lvl", fifo_level, 16);
      c = cyc;
      enable = 1;
      wait_rq(t);
      chk("f_lat", t, c + 200);
      chk("f_data", dac_data, 16'h1000);
      chk("f_lvl", fifo_level, 15);
      serve();
      wait_cyc(t + 199);
      in_data = 16'h2000;
      in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      wait_rq(t2);
      chk("pp_lat", t2, t + 200);
      chk("pp_data", dac_data, 16'h1001);
      chk("pp_lvl", fifo_level, 15);
      // reset while requesting
      rst_n = 0;
      #1;
      chk("ar_rq", dac_rq, 0);
      chk("ar_data", dac_data, 16'h8000);
      chk("ar_lvl", fifo_level, 0);
      chk("ar_late", late_count, 0);
      chk("ar_busy", busy, 0);
      chk("ar_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1;
      enable = 0;
      cnt = 0;
      repeat (1000) begin
         @(posedge clk); #1;
         if (dac_rq) cnt++;
      end
      chk("dis_no_rq", cnt, 0);
      // late counter saturation and clear priority
      @(negedge clk);
      c = cyc;
      enable = 1;
      wait_rq(t);
      chk("sat_lat", t, c + 200);
      chk("sat_under", underrun_count, 1);
      chk("sat_data", dac_data, 16'h8000);
      repeat (2) @(negedge clk);
      dac_st = 1;
      wait_cyc(t + 255*200 + 10);
      chk("late_255", late_count, 255);
      chk("sat_busy", busy, 1);
      wait_cyc(t + 256*200 + 10);
      chk("late_sat", late_count, 255);
      clear_counts = 1;
      @(negedge clk);
      clear_counts = 0;
      chk("late_clr", late_count, 0);
      chk("under_clr", underrun_count, 0);
      wait_cyc(t + 257*200 + 10);
      chk("late_1", late_count, 1);
      wait_cyc(t + 258*200 - 1);
      clear_counts = 1;
      @(negedge clk);
      clear_counts = 0;
      chk("clr_wins", late_count, 0);
      dac_st = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
